// File: rtl/im_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared definitions for the instruction-memory loader.
//               - Loader state encoding.
//               - Bytes per instruction word.
//               - Default IM geometry, shared with the IM write port and
//                 the top-level stall logic.
//               - Helper that identifies the states in which bytes are taken.
// Revision    : 1.0 - initial release
// ============================================================================
package im_loader_pkg;

    // Default instruction-memory geometry
    localparam int IM_DEPTH  = 101;   // words in IM
    localparam int IM_ADDR_W = 7;     // word-address width (PC>>2)
    localparam int IM_CNT_W  = 16;    // width of the word-count header

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } ld_state_t;

    // States in which the loader consumes stream bytes. The CPU is held in
    // stall for exactly the same set of states.
    function automatic logic is_loading(input ld_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA)   || (s == ST_CSUM);
    endfunction

endpackage : im_loader_pkg
`default_nettype wire

// File: rtl/im_loader_byte_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : im_byte_packer
// Description : 8->32 bit big-endian shift packer. The first accepted byte
//               of a word lands in bits 31:24. On the 4th accepted byte the
//               complete word is presented combinationally on o_word together
//               with a single-cycle o_word_ready.
// Ports       : clk          - rising-edge clock
//               rst          - asynchronous active-high reset
//               i_clr        - synchronous clear (new load); drops a partial word
//               i_accept     - a byte is handed over this cycle
//               i_data[7:0]  - the byte
//               o_word[31:0] - packed word; valid while o_word_ready = 1
//               o_word_ready - 4th byte of a word accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module im_byte_packer
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    localparam logic [BYTE_IDX_W-1:0] c_LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [23:0]           r_shift;   // the three bytes preceding the current one

    // The 4th byte is not stored: the word is assembled from the held bytes
    // plus the incoming byte, so the word is ready in the accept cycle itself.
    assign o_word       = {r_shift, i_data};
    assign o_word_ready = i_accept && !i_clr && (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_accept) begin
            r_shift <= {r_shift[15:0], i_data};
            r_idx   <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

endmodule : im_byte_packer
`default_nettype wire

// File: rtl/im_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Writer side of the instruction memory. Receives a byte
//               stream framed as LEN_HI, LEN_LO, 4*N data bytes [, checksum],
//               packs big-endian 32-bit words and writes them to consecutive
//               IM word addresses while holding the CPU in stall.
// Config      : IM_LOADER_CHECKSUM_EN - when defined, a trailing checksum byte
//               (XOR of LEN_HI, LEN_LO and all data bytes) is required.
// Ports       : clk                - rising-edge clock
//               reset              - asynchronous active-high reset
//               start              - pulse: begin a new load (aborts current)
//               in_valid           - in_data holds a byte
//               in_data[7:0]       - stream byte
//               in_ready           - byte accepted when in_valid & in_ready
//               mem_we             - single-cycle IM write strobe
//               mem_waddr[ADDR_W-1:0] - IM word address
//               mem_wdata[31:0]    - instruction word
//               cpu_stall          - CPU hold while a load is in progress
//               done               - last load completed successfully
//               error              - last load rejected (length / checksum)
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH  = IM_DEPTH,
    parameter int ADDR_W = IM_ADDR_W,
    parameter int CNT_W  = IM_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              done,
    output logic              error
);

    ld_state_t r_state;
    ld_state_t w_state_nxt;

    logic              w_rdy;
    logic              w_accept;
    logic              w_pk_accept;
    logic [31:0]       w_pk_word;
    logic              w_pk_ready;
    logic [15:0]       w_len_full;
    logic              w_len_zero;
    logic              w_len_over;
    logic              w_last_word;

    logic [7:0]        r_len_hi;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [31:0]       r_mem_wdata;

    // ------------------------------------------------------------------
    // Handshake. A byte presented together with start belongs to no frame
    // and is dropped, since start restarts the frame from LEN_HI.
    // ------------------------------------------------------------------
    assign w_rdy       = is_loading(r_state);
    assign w_accept    = in_valid && w_rdy && !start;
    assign w_pk_accept = w_accept && (r_state == ST_DATA);

    assign w_len_full  = {r_len_hi, in_data};
    assign w_len_zero  = (w_len_full == 16'd0);
    assign w_len_over  = (int'(w_len_full) > DEPTH);
    assign w_last_word = ((r_word_cnt + CNT_W'(1)) == r_len);

    im_byte_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .i_clr        (start),
        .i_accept     (w_pk_accept),
        .i_data       (in_data),
        .o_word       (w_pk_word),
        .o_word_ready (w_pk_ready)
    );

    // ------------------------------------------------------------------
    // Optional checksum: running XOR over every byte before the checksum.
    // ------------------------------------------------------------------
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else if (start) begin
            r_csum <= '0;
        end else if (w_accept && (r_state != ST_CSUM)) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = w_rdy;
        cpu_stall   = w_rdy;
        done        = (r_state == ST_DONE);
        error       = (r_state == ST_ERR);

        if (start) begin
            w_state_nxt = ST_LEN_HI;
        end else begin
            case (r_state)
                ST_LEN_HI: begin
                    if (w_accept) w_state_nxt = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        if (w_len_zero)      w_state_nxt = ST_DONE;
                        else if (w_len_over) w_state_nxt = ST_ERR;
                        else                 w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Leave DATA on the edge that launches the final write,
                    // so DONE coincides with the last mem_we pulse.
                    if (w_pk_ready && w_last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        w_state_nxt = ST_CSUM;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        w_state_nxt = (in_data == r_csum) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Header capture, word counter and IM write port.
    // The write port is registered: the word completed in one cycle is
    // written in the next. A pulse already launched when start arrives
    // is left to complete; start only prevents new ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_hi    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (start) begin
                r_len_hi   <= '0;
                r_len      <= '0;
                r_word_cnt <= '0;
            end else begin
                if (w_accept && (r_state == ST_LEN_HI)) begin
                    r_len_hi <= in_data;
                end
                if (w_accept && (r_state == ST_LEN_LO)) begin
                    r_len <= CNT_W'(w_len_full);
                end
                if (w_pk_ready) begin
                    r_mem_we    <= 1'b1;
                    r_mem_waddr <= r_word_cnt[ADDR_W-1:0];
                    r_mem_wdata <= w_pk_word;
                    r_word_cnt  <= r_word_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;

endmodule : im_loader
`default_nettype wire
